// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, false-start rejection,
// framing-error/overrun pulses and a single-entry ready/valid output register.
module uart_receiver #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int CW               = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t          state, state_nx;
   logic            rx_meta, rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;

   logic            hit_sample, hit_symbol;
   logic            cnt_clr, shift_en, byte_done, frame_bad;
   logic            fire;

   assign hit_sample = (cnt == CW'(SAMPLE_TIME - 1));
   assign hit_symbol = (cnt == CW'(SYMBOL_EDGE_TIME - 1));
   assign fire       = data_out_valid && data_out_ready;
   assign rx_busy    = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state   <= IDLE;
      end else begin
         rx_meta <= serial_in;
         rx_s    <= rx_meta;
         state   <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (!rx_s) state_nx = START;
         START:     if (hit_sample) state_nx = rx_s ? IDLE : DATA;
         DATA:      if (hit_symbol && bit_cnt == 3'd7) state_nx = STOP;
         STOP:      if (hit_symbol) state_nx = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb begin
      shift_en  = (state == DATA) && hit_symbol;
      byte_done = (state == STOP) && hit_symbol && rx_s;
      frame_bad = (state == STOP) && hit_symbol && !rx_s;
      // Counter restarts on every state change and at each data-bit boundary.
      cnt_clr   = (state_nx != state) || shift_en || (state == IDLE) || (state == WAIT_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt            <= '0;
         bit_cnt        <= '0;
         shreg          <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         framing_error  <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         cnt           <= cnt_clr ? '0 : cnt + CW'(1);
         framing_error <= frame_bad;
         overrun       <= byte_done && data_out_valid && !data_out_ready;

         if (state != DATA)  bit_cnt <= '0;
         else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;

         if (shift_en) shreg <= {rx_s, shreg[7:1]};

         // A byte landing in the same cycle as a fire replaces the consumed one.
         if (byte_done && (!data_out_valid || data_out_ready)) begin
            data_out       <= shreg;
            data_out_valid <= 1'b1;
         end else if (fire) begin
            data_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: scaled baud (16 clocks/bit), serial line driven from a
// byte-level frame generator, outputs collected by a fire/pulse monitor.
module tb_uart_receiver;

   localparam int CF   = 1_000_000;
   localparam int BR   = 62_500;
   localparam int SYM  = CF / BR;
   localparam int SAMP = SYM / 2;
   localparam int LAT  = 3 + SAMP + 9 * SYM;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       serial_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       framing_error;
   logic       overrun;
   logic       rx_busy;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         fe_cnt   = 0;
   int         ov_cnt   = 0;
   int         launch_cyc;
   logic [7:0] got_q[$];
   int         got_cyc[$];
   bit         rand_done;

   uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
      .clk(clk), .reset_n(reset_n), .serial_in(serial_in),
      .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .framing_error(framing_error), .overrun(overrun), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n) begin
         if (data_out_valid && data_out_ready) begin
            got_q.push_back(data_out);
            got_cyc.push_back(cyc);
         end
         if (framing_error) fe_cnt++;
         if (overrun) ov_cnt++;
      end
   end

   task automatic drive_bit(input logic v, input int n);
      serial_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      launch_cyc = cyc;
      drive_bit(1'b0, SYM);
      for (int i = 0; i < 8; i++) drive_bit(b[i], SYM);
      drive_bit(stop, SYM);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; serial_in = 1'b1; data_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_out); end
      n_checks++;
      if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", data_out_valid); end
      n_checks++;
      if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe got %b want 0", framing_error); end
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ov got %b want 0", overrun); end
      n_checks++;
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", rx_busy); end
      n_checks++;
      reset_n = 1'b1;
      drive_bit(1'b1, 4);
   endtask

   task automatic test_single;
      int fe0, ov0;
      fe0 = fe_cnt; ov0 = ov_cnt;
      got_q.delete(); got_cyc.delete();
      data_out_ready = 1'b1;
      send_frame(8'hA5, 1'b1);
      drive_bit(1'b1, 4);
      if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", got_q.size()); end
      n_checks++;
      if (got_q.size() > 0) begin
         if (got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", got_q[0]); end
         n_checks++;
         if (got_cyc[0] !== launch_cyc + LAT) begin
            n_fail++; $display("FAIL single_latency got %0d want %0d", got_cyc[0], launch_cyc + LAT);
         end
         n_checks++;
      end
      if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_clear got %b want 0", data_out_valid); end
      n_checks++;
      if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
         n_fail++; $display("FAIL single_errors got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
      end
      n_checks++;
   endtask

   task automatic test_glitch;
      int fe0;
      fe0 = fe_cnt;
      got_q.delete(); got_cyc.delete();
      drive_bit(1'b0, SAMP - 3);
      if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_early got %b want 1", rx_busy); end
      n_checks++;
      drive_bit(1'b1, SAMP + 4);
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", rx_busy); end
      n_checks++;
      if (data_out_valid !== 1'b0 || got_q.size() !== 0) begin
         n_fail++; $display("FAIL glitch_valid got %b/%0d want 0/0", data_out_valid, got_q.size());
      end
      n_checks++;
      if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_fe got %0d want 0", fe_cnt - fe0); end
      n_checks++;
   endtask

   task automatic test_framing;
      int fe0;
      fe0 = fe_cnt;
      got_q.delete(); got_cyc.delete();
      send_frame(8'h3C, 1'b0);
      drive_bit(1'b0, 3 * SYM);
      if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL framing_busy_held got %b want 1", rx_busy); end
      n_checks++;
      drive_bit(1'b1, 6);
      if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy_release got %b want 0", rx_busy); end
      n_checks++;
      if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL framing_pulses got %0d want 1", fe_cnt - fe0); end
      n_checks++;
      if (got_q.size() !== 0 || data_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL framing_no_data got %0d/%b want 0/0", got_q.size(), data_out_valid);
      end
      n_checks++;
   endtask

   task automatic test_overrun;
      int ov0;
      ov0 = ov_cnt;
      data_out_ready = 1'b0;
      got_q.delete(); got_cyc.delete();
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      drive_bit(1'b1, 8);
      if (data_out !== 8'h11 || data_out_valid !== 1'b1) begin
         n_fail++; $display("FAIL overrun_hold got %h/%b want 11/1", data_out, data_out_valid);
      end
      n_checks++;
      if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL overrun_pulses got %0d want 1", ov_cnt - ov0); end
      n_checks++;
      data_out_ready = 1'b1;
      drive_bit(1'b1, 2);
      if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got %b want 0", data_out_valid); end
      n_checks++;
      if (got_q.size() !== 1 || got_q[0] !== 8'h11) begin
         n_fail++; $display("FAIL overrun_consumed got n=%0d first=%h want 1/11", got_q.size(), got_q.size() ? got_q[0] : 8'hxx);
      end
      n_checks++;
   endtask

   task automatic test_simultaneous;
      int ov0;
      ov0 = ov_cnt;
      data_out_ready = 1'b0;
      got_q.delete(); got_cyc.delete();
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (LAT - 1) @(posedge clk);
            #1 data_out_ready = 1'b1;
            @(posedge clk);
            #1 data_out_ready = 1'b0;
         end
      join
      drive_bit(1'b1, 4);
      if (data_out !== 8'h22 || data_out_valid !== 1'b1) begin
         n_fail++; $display("FAIL simul_new got %h/%b want 22/1", data_out, data_out_valid);
      end
      n_checks++;
      if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL simul_overrun got %0d want 0", ov_cnt - ov0); end
      n_checks++;
      if (got_q.size() !== 1 || got_q[0] !== 8'h11) begin
         n_fail++; $display("FAIL simul_consumed got n=%0d want 1 byte 11", got_q.size());
      end
      n_checks++;
      data_out_ready = 1'b1;
      drive_bit(1'b1, 2);
   endtask

   task automatic test_reset_mid;
      got_q.delete(); got_cyc.delete();
      data_out_ready = 1'b1;
      fork
         send_frame(8'h5A, 1'b1);
         begin
            repeat (4 * SYM) @(posedge clk);
            #3 reset_n = 1'b0;
            #1;
            if (rx_busy !== 1'b0 || data_out !== 8'h00 || data_out_valid !== 1'b0) begin
               n_fail++; $display("FAIL midreset_outputs got busy=%b data=%h valid=%b want 0/00/0", rx_busy, data_out, data_out_valid);
            end
            n_checks++;
         end
      join
      drive_bit(1'b1, 3);
      reset_n = 1'b1;
      drive_bit(1'b1, 2 * SYM);
      send_frame(8'h96, 1'b1);
      drive_bit(1'b1, 4);
      if (got_q.size() !== 1 || got_q[0] !== 8'h96) begin
         n_fail++; $display("FAIL midreset_next got n=%0d first=%h want 1/96", got_q.size(), got_q.size() ? got_q[0] : 8'hxx);
      end
      n_checks++;
   endtask

   task automatic test_back_to_back_random;
      logic [7:0] sent[$];
      int fe0, ov0;
      fe0 = fe_cnt; ov0 = ov_cnt;
      got_q.delete(); got_cyc.delete();
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               logic [7:0] b;
               b = 8'($urandom);
               sent.push_back(b);
               send_frame(b, 1'b1);
               if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 5));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #2 data_out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      data_out_ready = 1'b1;
      drive_bit(1'b1, 6);
      if (got_q.size() !== sent.size()) begin
         n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size(), sent.size());
      end
      n_checks++;
      for (int i = 0; i < sent.size() && i < got_q.size(); i++) begin
         if (got_q[i] !== sent[i]) begin n_fail++; $display("FAIL rand_byte%0d got %h want %h", i, got_q[i], sent[i]); end
         n_checks++;
      end
      if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
         n_fail++; $display("FAIL rand_errors got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
      end
      n_checks++;
   endtask

   initial begin
      test_reset;
      test_single;
      test_glitch;
      test_framing;
      test_overrun;
      test_simultaneous;
      test_reset_mid;
      test_back_to_back_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
